// File: rtl/demux4_buf_if.sv
// Handshake and data bundle for the 1-to-4 buffered demultiplexer.
// The master side is the producer plus the four sinks; the slave side is the demux itself.
interface demux4_buf_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  demuxFlag;
    logic [31:0] w_demuxIn;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] w_demuxOut0;
    logic [31:0] w_demuxOut1;
    logic [31:0] w_demuxOut2;
    logic [31:0] w_demuxOut3;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;
    logic [7:0]  cnt2;
    logic [7:0]  cnt3;

    modport master (
        output in_valid, demuxFlag, w_demuxIn, out_ready,
        input  in_ready, out_valid,
        input  w_demuxOut0, w_demuxOut1, w_demuxOut2, w_demuxOut3,
        input  cnt0, cnt1, cnt2, cnt3
    );

    modport slave (
        input  in_valid, demuxFlag, w_demuxIn, out_ready,
        output in_ready, out_valid,
        output w_demuxOut0, w_demuxOut1, w_demuxOut2, w_demuxOut3,
        output cnt0, cnt1, cnt2, cnt3
    );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with a one-word buffer per output channel.
// A word is steered by demuxFlag into its channel buffer and held there until
// that sink takes it; a per-channel counter tracks accepted words modulo 256.
module demux4_buf (
    input logic         clk,
    input logic         reset,
    demux4_buf_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t state_q [4];
    chan_state_t state_d [4];
    logic [31:0] data_q  [4];
    logic [7:0]  cnt_q   [4];
    logic [3:0]  valid;
    logic [3:0]  load;
    logic [3:0]  drain;
    logic        ready;
    logic        accept;

    // Channel buffers advertise a word exactly while their FSM is FULL.
    always_comb begin
        valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            valid[k] = (state_q[k] == FULL);
        end
    end

    // The selected channel can take a word if it is empty or being drained this cycle.
    assign ready  = reset & (~valid[bus.demuxFlag] | bus.out_ready[bus.demuxFlag]);
    assign accept = bus.in_valid & ready;
    assign drain  = valid & bus.out_ready;

    // Only the addressed channel is loaded, and only on an accepted word.
    always_comb begin
        load = 4'b0000;
        if (accept) begin
            load[bus.demuxFlag] = 1'b1;
        end
    end

    // Per-channel next state: a load always wins, so drain plus load keeps FULL without a bubble.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            case (state_q[k])
                EMPTY: if (load[k]) state_d[k] = FULL;
                FULL: begin
                    if (load[k]) begin
                        state_d[k] = FULL;
                    end else if (drain[k]) begin
                        state_d[k] = EMPTY;
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
        end
    end

    // Channel state register; reset discards any buffered word without a drain.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
            end
        end
    end

    // Buffer data and accept counters move together on an accepted word; data persists while EMPTY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= 32'h0;
                cnt_q[k]  <= 8'h00;
            end
        end else if (accept) begin
            data_q[bus.demuxFlag] <= bus.w_demuxIn;
            cnt_q[bus.demuxFlag]  <= cnt_q[bus.demuxFlag] + 8'd1;
        end
    end

    assign bus.in_ready    = ready;
    assign bus.out_valid   = valid;
    assign bus.w_demuxOut0 = data_q[0];
    assign bus.w_demuxOut1 = data_q[1];
    assign bus.w_demuxOut2 = data_q[2];
    assign bus.w_demuxOut3 = data_q[3];
    assign bus.cnt0        = cnt_q[0];
    assign bus.cnt1        = cnt_q[1];
    assign bus.cnt2        = cnt_q[2];
    assign bus.cnt3        = cnt_q[3];

endmodule

// File: doc/demux4_buf.md
# demux4_buf

Registered 1-to-4 demultiplexer with one-entry output buffers and valid/ready handshakes on every port. A 32-bit word arrives on a single input channel with a 2-bit destination select. It is captured into the buffer of the selected output channel and presented there until that sink accepts it. This is the distribution counterpart to the datapath's 4:1 source-select muxes: one producer, up to four independent consumers, each with its own backpressure.

## Interface
- No parameters; data width is fixed at 32, channel count at 4, counter width at 8.
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low; state clears on a rising clk edge while low
- in_valid  input  1  producer has a word on w_demuxIn
- in_ready  output  1  block accepts the word this cycle
- demuxFlag  input  2  destination channel (0..3), sampled with w_demuxIn
- w_demuxIn  input  32  input word
- out_valid  output  4  bit k: channel k buffer holds a word
- out_ready  input  4  bit k: sink k accepts the word this cycle
- w_demuxOut0..w_demuxOut3  output  32 each  channel buffer contents
- cnt0..cnt3  output  8 each  words accepted into channel k, modulo 256

## Operation
- Each channel k has a 2-state FSM: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
- in_ready = reset & (!out_valid[demuxFlag] | out_ready[demuxFlag]).
  - in_ready is combinational from demuxFlag, out_valid and out_ready.
  - in_ready is independent of in_valid.
- Accept event: in_valid & in_ready. On acceptance, buffer demuxFlag loads w_demuxIn, enters or stays FULL, and its counter increments.
- Drain event on channel k: out_valid[k] & out_ready[k].
- Channel k transitions:
  - EMPTY -> FULL on an accept to k.
  - FULL -> EMPTY on a drain with no accept to k.
  - FULL -> FULL with new data on a simultaneous drain and accept to k (pass-through, no bubble).
  - FULL holds its data while out_ready[k]=0.
- At most one channel is loaded per cycle. The other channels drain independently in the same cycle.
- w_demuxOutk retains its last loaded value in EMPTY. Sinks qualify it with out_valid[k].
- Counters wrap 255 -> 0 with no saturation and no flag.
- demuxFlag and w_demuxIn are ignored when in_valid=0. demuxFlag may change every cycle.
- When in_valid=1 and in_ready=0, the producer must hold the word and demuxFlag stable until accepted. The block does not check this.

## Timing
- Reset (reset low at a clk edge):
  - out_valid=4'b0000.
  - All w_demuxOutk=32'h0.
  - All cntk=8'h00.
  - in_ready=0 for as long as reset is low.
- Reset asserted mid-operation discards all buffered words; no drain is signalled for them.
- Latency: a word accepted at edge N is visible on w_demuxOutk with out_valid[k]=1 immediately after edge N, i.e. in cycle N+1.
- Throughput: one word per cycle sustained to any channel or mix of channels, provided each destination sink is ready or its buffer is empty.
- Counters update on the same edge as the accept.

## Test plan
- Reset: drive random inputs with reset=0 for 3 cycles.
  - -> in_ready=0, out_valid=0, all outputs and counters 0; no accept occurs.
- Single routing: out_ready=4'b1111; send 32'hA0000000, A1, A2, A3 with demuxFlag=0,1,2,3 on consecutive cycles.
  - -> each out_valid[k] pulses for one cycle, one cycle after its accept, with the matching data.
  - -> cntk=1 for every channel.
- Backpressure: out_ready[2]=0; send 32'hDEADBEEF to channel 2, then 32'h12345678 to channel 2.
  - -> first word held on w_demuxOut2; in_ready=0 while demuxFlag=2.
  - -> switching demuxFlag to 1 with the same word gives in_ready=1.
- Pass-through: channel 3 FULL with 32'h1; assert out_ready[3]=1 and send 32'h2 to channel 3 in the same cycle.
  - -> in_ready=1; next cycle out_valid[3]=1 with 32'h2; cnt3 increments.
- Wrap: push 257 words to channel 0 with out_ready[0]=1.
  - -> cnt0 reads 255 after 255 words, 0 after 256, 1 after 257.
- Mid-operation reset: fill channels 0 and 1, then pulse reset low for 1 cycle.
  - -> out_valid=0 and counters 0 on the next cycle; in_ready returns to 1 the cycle after reset releases.
